// File: rtl/stopwatch_sequencer.sv
// rtl/stopwatch_sequencer.sv - button-driven stopwatch control sequencer for an external BCD counter
//
// Purpose: synchronises and debounces four raw buttons, turns debounced
// presses into one-cycle events, and runs an IDLE/RUNNING/PAUSED/LAP state
// machine. It prescales the clock into count_inc ticks and selects either the
// live count or a frozen lap value for display.
//
// Ports:
//   CLK        in   1  single clock, rising edge
//   RST        in   1  synchronous active-high reset
//   BTN_CLEAR  in   1  raw clear button
//   BTN_START  in   1  raw start button
//   BTN_STOP   in   1  raw stop button
//   BTN_LAP    in   1  raw lap button
//   count_in   in   8  two-digit BCD count from the external counter
//   count_inc  out  1  one-cycle increment command
//   count_clr  out  1  one-cycle clear command
//   disp_out   out  8  BCD value for the display controller
//   state      out  2  IDLE=00 RUNNING=01 PAUSED=10 LAP=11
//   running    out  1  high in RUNNING or LAP
module stopwatch_sequencer #(
  parameter int TICK_DIV   = 1200000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_CLEAR,
  input  logic       BTN_START,
  input  logic       BTN_STOP,
  input  logic       BTN_LAP,
  input  logic [7:0] count_in,
  output logic       count_inc,
  output logic       count_clr,
  output logic [7:0] disp_out,
  output logic [1:0] state,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } state_t;

  // The debounce counter only needs to reach DEB_CYCLES-1.
  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  // Button bit order: 0 clear, 1 stop, 2 start, 3 lap.
  logic [3:0]    w_btn_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_q;
  logic [3:0]    r_press;
  logic [DW-1:0] r_deb_cnt [4];

  assign w_btn_raw = {BTN_LAP, BTN_START, BTN_STOP, BTN_CLEAR};

  // Synchroniser, per-button debounce, and registered rising-edge detect.
  // The press register adds the final cycle so the event appears
  // DEB_CYCLES+2 edges after the first high sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb & ~r_deb_q;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
          end
        end else begin
          // Agreement (including a bounce back) restarts the count.
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  logic w_clear;
  logic w_stop;
  logic w_start;
  logic w_lap;

  assign w_clear = r_press[0];
  assign w_stop  = r_press[1];
  assign w_start = r_press[2];
  assign w_lap   = r_press[3];

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_lap;
  logic          r_inc;
  logic          r_clr;
  logic [7:0]    r_disp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_lap     <= '0;
      r_inc     <= 1'b0;
      r_clr     <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_disp <= (r_state == ST_LAP) ? r_lap : count_in;
      r_inc  <= 1'b0;
      r_clr  <= 1'b0;

      // Prescaler advances only while running, so a pause freezes the phase.
      if (r_running) begin
        if (r_presc == TICK_LAST) begin
          r_presc <= '0;
          r_inc   <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end

      // Priority chain: clear > stop > start > lap. A higher event that is
      // ignored in the current state still swallows the lower ones.
      if (w_clear) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_clr     <= 1'b1;
        r_inc     <= 1'b0;
        r_presc   <= '0;
        r_lap     <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSED: begin
            if (!w_stop && w_start) begin
              r_state   <= ST_RUNNING;
              r_running <= 1'b1;
            end
          end
          ST_RUNNING: begin
            if (w_stop) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end else if (!w_start && w_lap) begin
              r_state <= ST_LAP;
              r_lap   <= count_in;
            end
          end
          ST_LAP: begin
            if (w_stop) begin
              r_state   <= ST_PAUSED;
              r_running <= 1'b0;
            end else if (!w_start && w_lap) begin
              r_state <= ST_RUNNING;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_inc = r_inc;
  assign count_clr = r_clr;
  assign disp_out  = r_disp;
  assign state     = r_state;
  assign running   = r_running;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb/tb_stopwatch_sequencer.sv - directed self-checking bench for stopwatch_sequencer
module tb_stopwatch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_clear;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_lap;
  logic [7:0] count_in;
  logic       count_inc;
  logic       count_clr;
  logic [7:0] disp_out;
  logic [1:0] state;
  logic       running;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stopwatch_sequencer #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTN_CLEAR(btn_clear),
    .BTN_START(btn_start),
    .BTN_STOP (btn_stop),
    .BTN_LAP  (btn_lap),
    .count_in (count_in),
    .count_inc(count_inc),
    .count_clr(count_clr),
    .disp_out (disp_out),
    .state    (state),
    .running  (running)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_total++; if (state !== 2'b00) $display("FAIL reset_state: got %0h want 0", state); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running: got %0b want 0", running); else n_pass++;
    n_total++; if (count_inc !== 1'b0) $display("FAIL reset_inc: got %0b want 0", count_inc); else n_pass++;
    n_total++; if (count_clr !== 1'b0) $display("FAIL reset_clr: got %0b want 0", count_clr); else n_pass++;
    n_total++; if (disp_out !== 8'h00) $display("FAIL reset_disp: got %0h want 00", disp_out); else n_pass++;
    rst = 1'b0;
  endtask

  // First high sample at edge 0; state flips at edge 6; ticks at edges 10, 14, 18.
  task automatic test_start();
    btn_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_total++; if (state !== 2'b00) $display("FAIL start_early edge %0d: got %0h want 0", k, state); else n_pass++;
    end
    btn_start = 1'b0;
    cyc();
    n_total++; if (state !== 2'b01) $display("FAIL start_state: got %0h want 1", state); else n_pass++;
    n_total++; if (running !== 1'b1) $display("FAIL start_running: got %0b want 1", running); else n_pass++;
    for (int k = 7; k <= 18; k++) begin
      logic exp_inc;
      cyc();
      exp_inc = (k == 10 || k == 14 || k == 18);
      n_total++; if (count_inc !== exp_inc) $display("FAIL start_tick edge %0d: got %0b want %0b", k, count_inc, exp_inc); else n_pass++;
    end
  endtask

  task automatic test_bounce();
    btn_stop = 1'b1; cyc(2);
    btn_stop = 1'b0; cyc(1);
    btn_stop = 1'b1; cyc(2);
    btn_stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_total++; if (state !== 2'b01) $display("FAIL bounce_state cyc %0d: got %0h want 1", k, state); else n_pass++;
    end
  endtask

  task automatic test_lap();
    count_in = 8'h37;
    btn_lap  = 1'b1;
    cyc(6);
    btn_lap = 1'b0;
    cyc();
    n_total++; if (state !== 2'b11) $display("FAIL lap_state: got %0h want 3", state); else n_pass++;
    count_in = 8'h41;
    for (int k = 0; k < 8; k++) begin
      cyc();
      n_total++; if (disp_out !== 8'h37) $display("FAIL lap_hold cyc %0d: got %0h want 37", k, disp_out); else n_pass++;
    end
    n_total++; if (running !== 1'b1) $display("FAIL lap_running: got %0b want 1", running); else n_pass++;
    btn_lap = 1'b1;
    cyc(6);
    btn_lap = 1'b0;
    cyc();
    n_total++; if (state !== 2'b01) $display("FAIL lap2_state: got %0h want 1", state); else n_pass++;
    cyc();
    n_total++; if (disp_out !== 8'h41) $display("FAIL lap2_disp: got %0h want 41", disp_out); else n_pass++;
    count_in = 8'h42;
    cyc();
    n_total++; if (disp_out !== 8'h42) $display("FAIL lap2_follow: got %0h want 42", disp_out); else n_pass++;
    cyc(6);
  endtask

  // Align to a tick at edge k; stop first sampled at k+4 lands the FSM
  // transition at k+10 with the prescaler frozen at 2.
  task automatic test_pause_resume();
    int t = 0;
    while (count_inc !== 1'b1 && t < 10) begin
      cyc();
      t++;
    end
    n_total++; if (count_inc !== 1'b1) $display("FAIL pause_align: got %0b want 1 within 10 cycles", count_inc); else n_pass++;
    cyc(3);
    btn_stop = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      logic exp_inc;
      cyc();
      exp_inc = (i == 1 || i == 5);
      n_total++; if (count_inc !== exp_inc) $display("FAIL pause_pre_tick %0d: got %0b want %0b", i, count_inc, exp_inc); else n_pass++;
    end
    btn_stop = 1'b0;
    cyc();
    n_total++; if (state !== 2'b10) $display("FAIL pause_state: got %0h want 2", state); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL pause_running: got %0b want 0", running); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_total++; if ({state, count_inc} !== 3'b100) $display("FAIL pause_hold cyc %0d: got state %0h inc %0b want state 2 inc 0", k, state, count_inc); else n_pass++;
    end
    btn_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_total++; if (count_inc !== 1'b0) $display("FAIL pause_press_inc cyc %0d: got %0b want 0", k, count_inc); else n_pass++;
    end
    btn_start = 1'b0;
    cyc();
    n_total++; if (state !== 2'b01) $display("FAIL resume_state: got %0h want 1", state); else n_pass++;
    n_total++; if (count_inc !== 1'b0) $display("FAIL resume_inc0: got %0b want 0", count_inc); else n_pass++;
    cyc();
    n_total++; if (count_inc !== 1'b0) $display("FAIL resume_inc1: got %0b want 0", count_inc); else n_pass++;
    cyc();
    n_total++; if (count_inc !== 1'b1) $display("FAIL resume_inc2: got %0b want 1", count_inc); else n_pass++;
    cyc();
    n_total++; if (count_inc !== 1'b0) $display("FAIL resume_inc3: got %0b want 0", count_inc); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int n_clr = 0;
    int n_inc = 0;
    btn_stop = 1'b1;
    cyc(6);
    btn_stop = 1'b0;
    cyc();
    n_total++; if (state !== 2'b10) $display("FAIL simul_paused: got %0h want 2", state); else n_pass++;
    cyc(8);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_clr += int'(count_clr);
      n_inc += int'(count_inc);
    end
    btn_clear = 1'b0;
    btn_start = 1'b0;
    cyc();
    n_clr += int'(count_clr);
    n_inc += int'(count_inc);
    n_total++; if (state !== 2'b00) $display("FAIL simul_state: got %0h want 0", state); else n_pass++;
    n_total++; if (count_clr !== 1'b1) $display("FAIL simul_clr_edge: got %0b want 1", count_clr); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL simul_running: got %0b want 0", running); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      cyc();
      n_clr += int'(count_clr);
      n_inc += int'(count_inc);
    end
    n_total++; if (n_clr !== 1) $display("FAIL simul_clr_count: got %0d want 1", n_clr); else n_pass++;
    n_total++; if (n_inc !== 0) $display("FAIL simul_inc_count: got %0d want 0", n_inc); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL simul_stay_idle: got %0h want 0", state); else n_pass++;
  endtask

  task automatic test_midrun_reset();
    int n_pulse = 0;
    btn_start = 1'b1;
    cyc(6);
    btn_start = 1'b0;
    cyc();
    n_total++; if (state !== 2'b01) $display("FAIL mrst_run: got %0h want 1", state); else n_pass++;
    cyc(6);
    count_in = 8'h55;
    btn_lap  = 1'b1;
    cyc(6);
    btn_lap = 1'b0;
    cyc();
    n_total++; if (state !== 2'b11) $display("FAIL mrst_lap: got %0h want 3", state); else n_pass++;
    cyc();
    n_total++; if (disp_out !== 8'h55) $display("FAIL mrst_lapdisp: got %0h want 55", disp_out); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_total++; if (state !== 2'b00) $display("FAIL mrst_state: got %0h want 0", state); else n_pass++;
    n_total++; if (disp_out !== 8'h00) $display("FAIL mrst_disp: got %0h want 00", disp_out); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL mrst_running: got %0b want 0", running); else n_pass++;
    n_total++; if ({count_inc, count_clr} !== 2'b00) $display("FAIL mrst_pulses: got %0b want 00", {count_inc, count_clr}); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      cyc();
      n_pulse += int'(count_inc) + int'(count_clr);
    end
    n_total++; if (n_pulse !== 0) $display("FAIL mrst_quiet: got %0d pulses want 0", n_pulse); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL mrst_idle: got %0h want 0", state); else n_pass++;
  endtask

  // A button held through reset release acts as a fresh press.
  task automatic test_held_through_reset();
    btn_start = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_total++; if (state !== 2'b00) $display("FAIL held_early edge %0d: got %0h want 0", k, state); else n_pass++;
    end
    cyc();
    n_total++; if (state !== 2'b01) $display("FAIL held_state: got %0h want 1", state); else n_pass++;
    btn_start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    btn_clear = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_lap   = 1'b0;
    count_in  = 8'h00;
    @(negedge clk);
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_pause_resume();
    test_simultaneous();
    test_midrun_reset();
    test_held_through_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
